// File: rtl/adder_bist_checker.sv
// adder_bist_checker: exhaustive self-test engine for a WIDTH-bit ripple adder.
// Sweeps every {cin,a,b} vector, waits SETTLE cycles, compares the adder's
// {co,s} against a+b+cin, counts mismatches and records the first failure.
// Optional build macro BIST_STOP_ON_FAIL_EN: when defined, the sweep stops on
// the first mismatch and leaves dut_* frozen on the failing vector.
//
// state  | meaning
// IDLE   | waiting for start after reset
// SETTLE | vector presented, waiting for the adder to settle
// CHECK  | sampling and comparing the adder response
// DONE   | sweep complete, results held until next start
module adder_bist_checker #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] dut_a,
  output logic [WIDTH-1:0] dut_b,
  output logic             dut_cin,
  input  logic [WIDTH-1:0] dut_s,
  input  logic             dut_co,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_count,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic             fail_cin,
  output logic [WIDTH-1:0] fail_s,
  output logic             fail_co
);

  localparam int VW = 2 * WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

  state_t          state, state_next;
  logic [VW-1:0]   vec;
  logic [3:0]      settle_cnt;
  logic [WIDTH:0]  golden;
  logic            mismatch;
  logic            last_vec;
  logic            settle_tc;
  logic            launch;
  logic            advance;
  logic            check;
  logic [15:0]     err_next;

  // Operands come straight from the vector register: {cin, a, b}.
  assign dut_b   = vec[WIDTH-1:0];
  assign dut_a   = vec[2*WIDTH-1:WIDTH];
  assign dut_cin = vec[VW-1];

  assign golden    = {1'b0, dut_a} + {1'b0, dut_b} + {{WIDTH{1'b0}}, dut_cin};
  assign mismatch  = ({dut_co, dut_s} != golden);
  assign last_vec  = &vec;
  assign settle_tc = (settle_cnt == 4'd0);

  assign busy = (state == S_SETTLE) || (state == S_CHECK);
  assign done = (state == S_DONE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic and per-cycle control strobes.
  always_comb begin
    state_next = state;
    launch     = 1'b0;
    advance    = 1'b0;
    check      = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          launch     = 1'b1;
          state_next = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (settle_tc) state_next = S_CHECK;
      end
      S_CHECK: begin
        check = 1'b1;
`ifdef BIST_STOP_ON_FAIL_EN
        if (mismatch || last_vec) begin
          state_next = S_DONE;
        end else begin
          advance    = 1'b1;
          state_next = S_SETTLE;
        end
`else
        if (last_vec) begin
          state_next = S_DONE;
        end else begin
          advance    = 1'b1;
          state_next = S_SETTLE;
        end
`endif
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Saturating error count for the coming cycle.
  always_comb begin
    err_next = err_count;
    if (launch)
      err_next = 16'd0;
    else if (check && mismatch && (err_count != 16'hFFFF))
      err_next = err_count + 16'd1;
  end

  // Vector counter and settle down-counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec        <= '0;
      settle_cnt <= 4'd0;
    end else begin
      if (launch)
        vec <= '0;
      else if (advance)
        vec <= vec + 1'b1;
      if (launch || advance)
        settle_cnt <= 4'(SETTLE - 1);
      else if ((state == S_SETTLE) && !settle_tc)
        settle_cnt <= settle_cnt - 4'd1;
    end
  end

  // Error count, first-failure capture and registered pass flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= 16'd0;
      fail_a    <= '0;
      fail_b    <= '0;
      fail_cin  <= 1'b0;
      fail_s    <= '0;
      fail_co   <= 1'b0;
      pass      <= 1'b0;
    end else begin
      err_count <= err_next;
      if (launch) begin
        fail_a   <= '0;
        fail_b   <= '0;
        fail_cin <= 1'b0;
        fail_s   <= '0;
        fail_co  <= 1'b0;
        pass     <= 1'b0;
      end else begin
        if (check && mismatch && (err_count == 16'd0)) begin
          fail_a   <= dut_a;
          fail_b   <= dut_b;
          fail_cin <= dut_cin;
          fail_s   <= dut_s;
          fail_co  <= dut_co;
        end
        if ((state == S_CHECK) && (state_next == S_DONE))
          pass <= (err_next == 16'd0);
      end
    end
  end

endmodule

// File: tb/tb_adder_bist_checker.sv
// Testbench for adder_bist_checker: faulty-adder environment, arithmetic
// reference model over the whole vector space, queue-based scoreboard.
module tb_adder_bist_checker;

  localparam int WIDTH  = 4;
  localparam int SETTLE = 1;
  localparam int NVEC   = 1 << (2 * WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] dut_a, dut_b, dut_s;
  logic             dut_cin, dut_co;
  logic             busy, done, pass;
  logic [15:0]      err_count;
  logic [WIDTH-1:0] fail_a, fail_b, fail_s;
  logic             fail_cin, fail_co;

  adder_bist_checker #(.WIDTH(WIDTH), .SETTLE(SETTLE)) u_dut (
    .clk(clk), .rst(rst), .start(start),
    .dut_a(dut_a), .dut_b(dut_b), .dut_cin(dut_cin),
    .dut_s(dut_s), .dut_co(dut_co),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_a(fail_a), .fail_b(fail_b), .fail_cin(fail_cin),
    .fail_s(fail_s), .fail_co(fail_co)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // 0: good adder, 1: s[0] stuck-at-0, 2: co stuck-at-0, 3: random per-vector flips
  int mode = 0;
  int bad_mask [NVEC];
  int bad_gen = 0;

  function automatic int fault_out(int m, int v);
    int a, b, cin, r;
    a   = (v >> WIDTH) & ((1 << WIDTH) - 1);
    b   = v & ((1 << WIDTH) - 1);
    cin = (v >> (2 * WIDTH)) & 1;
    r   = a + b + cin;
    case (m)
      1: r = r & ~1;
      2: r = r & ((1 << WIDTH) - 1);
      3: r = r ^ bad_mask[v];
      default: ;
    endcase
    return r;
  endfunction

  // Adder under test as seen by the checker.
  always @(dut_a or dut_b or dut_cin or mode or bad_gen) begin
    int r;
    r = fault_out(mode, int'({dut_cin, dut_a, dut_b}));
    dut_s  = r[WIDTH-1:0];
    dut_co = r[WIDTH];
  end

  typedef struct {
    int err, pss, fa, fb, fcin, fs, fco, lat, da, db, dcin, start_cyc;
  } exp_t;

  exp_t sb [$];

  function automatic exp_t model(int m);
    exp_t e;
    int first, last, gold, obs;
    first = -1;
    e.err = 0; e.fa = 0; e.fb = 0; e.fcin = 0; e.fs = 0; e.fco = 0;
    e.start_cyc = 0;
    for (int v = 0; v < NVEC; v++) begin
      gold = ((v >> WIDTH) & 15) + (v & 15) + ((v >> (2 * WIDTH)) & 1);
      obs  = fault_out(m, v);
      if (obs != gold) begin
        e.err++;
        if (first < 0) begin
          first  = v;
          e.fa   = (v >> WIDTH) & 15;
          e.fb   = v & 15;
          e.fcin = (v >> (2 * WIDTH)) & 1;
          e.fs   = obs & 15;
          e.fco  = (obs >> WIDTH) & 1;
        end
`ifdef BIST_STOP_ON_FAIL_EN
        break;
`endif
      end
    end
    last = NVEC - 1;
`ifdef BIST_STOP_ON_FAIL_EN
    if (first >= 0) last = first;
`endif
    if (e.err > 65535) e.err = 65535;
    e.pss  = (e.err == 0) ? 1 : 0;
    e.lat  = (last + 1) * (SETTLE + 1);
    e.da   = (last >> WIDTH) & 15;
    e.db   = last & 15;
    e.dcin = (last >> (2 * WIDTH)) & 1;
    return e;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: on each rising done, pop the expected result and compare.
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_done <= 1'b0;
    end else begin
      if (done && !prev_done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("latency",   cyc - e.start_cyc, e.lat);
          chk("err_count", int'(err_count), e.err);
          chk("pass",      int'(pass), e.pss);
          chk("busy_done", int'(busy), 0);
          chk("fail_a",    int'(fail_a), e.fa);
          chk("fail_b",    int'(fail_b), e.fb);
          chk("fail_cin",  int'(fail_cin), e.fcin);
          chk("fail_s",    int'(fail_s), e.fs);
          chk("fail_co",   int'(fail_co), e.fco);
          chk("dut_a",     int'(dut_a), e.da);
          chk("dut_b",     int'(dut_b), e.db);
          chk("dut_cin",   int'(dut_cin), e.dcin);
        end
      end
      prev_done <= done;
    end
  end

  task automatic start_sweep(output exp_t e);
    @(negedge clk);
    start = 1'b1;
    e = model(mode);
    @(negedge clk);
    start = 1'b0;
    e.start_cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (sb.size() == 0) return;
    end
    chk("done_timeout", 0, 1);
    sb.delete();
  endtask

  task automatic wait_until(int t0, int n);
    while (cyc - t0 < n) @(negedge clk);
  endtask

  task automatic randomize_faults();
    for (int v = 0; v < NVEC; v++)
      bad_mask[v] = ($urandom_range(0, 40) == 0) ? int'($urandom_range(1, 31)) : 0;
    bad_gen++;
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_pass"}, int'(pass), 0);
    chk({tag, "_err"},  int'(err_count), 0);
    chk({tag, "_fail"}, int'({fail_a, fail_b, fail_cin, fail_s, fail_co}), 0);
    chk({tag, "_vec"},  int'({dut_cin, dut_a, dut_b}), 0);
  endtask

  initial begin
    exp_t e;
    for (int v = 0; v < NVEC; v++) bad_mask[v] = 0;
    #1;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_all_zero("post_reset");

    mode = 0; start_sweep(e); wait_done();
    mode = 2; start_sweep(e); wait_done();

    // Reset mid-sweep clears everything at once.
    mode = 1; start_sweep(e);
    wait_until(e.start_cyc, 300);
    rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mode = 1; start_sweep(e); wait_done();

    // Start from DONE (with errors present) begins a fresh sweep.
    mode = 0; start_sweep(e);
    chk("restart_err",  int'(err_count), 0);
    chk("restart_done", int'(done), 0);
    chk("restart_busy", int'(busy), 1);
    wait_done();

    // Start while busy is ignored; completion timing is unchanged.
    for (int k = 0; k < 3; k++) begin
      mode = 3; randomize_faults(); start_sweep(e);
      if (e.lat > 60) begin
        wait_until(e.start_cyc, 50);
        chk("busy_mid", int'(busy), 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      wait_done();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
